// File: rtl/inst_fetch_queue_pkg.sv
// inst_fetch_queue_pkg: shared widths, reset PC and fetch FSM encoding
package inst_fetch_queue_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int ENTRY_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;
endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// inst_queue_fifo: {pc,inst} queue with clear, combinational head read
module inst_queue_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  assign rdata = mem[head];
  assign full = count == DEPTH[AW:0];
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) mem[tail] <= wdata;
      tail <= tail + AW'(push);
      head <= head + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential fetch with one outstanding icache request, queued to decode
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  output logic              icache_req_valid,
  output logic [ADDR_W-1:0] icache_req_addr,
  input  logic              icache_req_ready,
  input  logic              icache_resp_valid,
  input  logic [INST_W-1:0] icache_resp_inst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              inst_flag,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              dispatch_ready
);
  fetch_state_t state;
  logic [ADDR_W-1:0] fetch_pc;
  logic full, empty, accept, push, pop, clear;
  logic [ENTRY_W-1:0] head;
  assign icache_req_valid = rst_n && rdy && !flush && state == IDLE && !full;
  assign icache_req_addr = fetch_pc;
  assign accept = icache_req_valid && icache_req_ready;
  assign clear = rdy && flush;
  assign push = rdy && !flush && state == WAIT && icache_resp_valid;
  assign inst_flag = rst_n && rdy && !flush && !empty;
  assign pop = inst_flag && dispatch_ready;
  assign {inst_pc, inst} = head;
  // fetch_pc runs one word ahead while WAIT, so the pushed PC is fetch_pc-4
  inst_queue_fifo #(.DEPTH(QUEUE_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .clear(clear),
    .wdata({fetch_pc - 32'd4, icache_resp_inst}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
    end else if (rdy) begin
      fetch_pc <= flush ? flush_pc & ~32'h3 : accept ? fetch_pc + 32'd4 : fetch_pc;
      state <= state == IDLE ? (accept ? WAIT : IDLE) :
               icache_resp_valid ? IDLE :
               (flush || state == DISCARD) ? DISCARD : WAIT;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of fetch, queueing, flush, wrap and async reset
module tb_inst_fetch_queue;
  logic clk = 0, rst_n = 0, rdy = 1;
  logic icache_req_valid, icache_req_ready = 1;
  logic [31:0] icache_req_addr;
  logic icache_resp_valid = 0;
  logic [31:0] icache_resp_inst = 0;
  logic flush = 0;
  logic [31:0] flush_pc = 0;
  logic inst_flag;
  logic [31:0] inst, inst_pc;
  logic dispatch_ready = 1;
  int nvec = 0, nerr = 0;
  logic acc, pend;
  logic [31:0] acc_addr, pend_addr;
  int resp_delay = 0, dcnt = 0;
  always #5 clk = ~clk;
  inst_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .icache_req_valid(icache_req_valid), .icache_req_addr(icache_req_addr),
    .icache_req_ready(icache_req_ready), .icache_resp_valid(icache_resp_valid),
    .icache_resp_inst(icache_resp_inst), .flush(flush), .flush_pc(flush_pc),
    .inst_flag(inst_flag), .inst(inst), .inst_pc(inst_pc), .dispatch_ready(dispatch_ready)
  );
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // one clock; icache model answers resp_delay cycles after an accept
  task automatic tick();
    acc = icache_req_valid && icache_req_ready;
    acc_addr = icache_req_addr;
    @(posedge clk);
    @(negedge clk);
    icache_resp_valid = 0;
    if (acc) begin
      pend = 1;
      pend_addr = acc_addr;
      dcnt = resp_delay;
    end
    if (pend) begin
      if (dcnt == 0) begin
        icache_resp_valid = 1;
        icache_resp_inst = f(pend_addr);
        pend = 0;
      end else dcnt--;
    end
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    pend = 0;
    acc = 0;
    icache_resp_valid = 0;
    flush = 0;
    rdy = 1;
    resp_delay = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask
  initial begin
    int n, accs;
    logic [31:0] first_addr;
    logic got;
    pend = 0;
    #1;
    chk("rst_req_valid", {31'd0, icache_req_valid}, 0);
    chk("rst_req_addr", icache_req_addr, 0);
    chk("rst_inst_flag", {31'd0, inst_flag}, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    // 1: streaming fetch
    do_reset();
    chk("t1_req_valid", {31'd0, icache_req_valid}, 1);
    chk("t1_req_addr", icache_req_addr, 0);
    chk("t1_flag0", {31'd0, inst_flag}, 0);
    tick();
    chk("t1_wait_req", {31'd0, icache_req_valid}, 0);
    chk("t1_flag1", {31'd0, inst_flag}, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_flag_hi", {31'd0, inst_flag}, 1);
      chk("t1_pc", inst_pc, 32'(4 * k));
      chk("t1_inst", inst, f(32'(4 * k)));
      tick();
      chk("t1_flag_lo", {31'd0, inst_flag}, 0);
      tick();
    end
    rdy = 0;
    #1;
    chk("rdy0_flag", {31'd0, inst_flag}, 0);
    chk("rdy0_req", {31'd0, icache_req_valid}, 0);
    tick();
    tick();
    rdy = 1;
    #1;
    chk("rdy1_flag", {31'd0, inst_flag}, 1);
    chk("rdy1_pc", inst_pc, 32'h10);
    // 2: fill to full, then drain in order
    do_reset();
    dispatch_ready = 0;
    #1;
    accs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      accs += int'(acc);
    end
    chk("t2_accepts", 32'(accs), 16);
    chk("t2_full_req", {31'd0, icache_req_valid}, 0);
    dispatch_ready = 1;
    #1;
    got = 0;
    first_addr = 32'hX;
    for (int i = 0; i < 16; i++) begin
      chk("t2_flag", {31'd0, inst_flag}, 1);
      chk("t2_pc", inst_pc, 32'(4 * i));
      if (!got && icache_req_valid) begin
        got = 1;
        first_addr = icache_req_addr;
      end
      tick();
    end
    chk("t2_resume_addr", first_addr, 32'h40);
    // 3: flush while WAIT, late response discarded
    do_reset();
    resp_delay = 3;
    tick();
    flush = 1;
    flush_pc = 32'h100;
    #1;
    chk("t3_flush_flag", {31'd0, inst_flag}, 0);
    chk("t3_flush_req", {31'd0, icache_req_valid}, 0);
    tick();
    flush = 0;
    #1;
    n = 0;
    while (!icache_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t3_discard_cycles", 32'(n), 3);
    chk("t3_req_addr", icache_req_addr, 32'h100);
    chk("t3_dropped", {31'd0, inst_flag}, 0);
    resp_delay = 0;
    tick();
    tick();
    chk("t3_flag", {31'd0, inst_flag}, 1);
    chk("t3_pc", inst_pc, 32'h100);
    chk("t3_inst", inst, f(32'h100));
    // 4: flush coincident with resp and pop; unaligned flush_pc
    do_reset();
    dispatch_ready = 0;
    tick();
    tick();
    tick();
    chk("t4_pre_flag", {31'd0, inst_flag}, 1);
    chk("t4_pre_resp", {31'd0, icache_resp_valid}, 1);
    dispatch_ready = 1;
    flush = 1;
    flush_pc = 32'h203;
    #1;
    chk("t4_flush_flag", {31'd0, inst_flag}, 0);
    tick();
    flush = 0;
    #1;
    chk("t4_empty", {31'd0, inst_flag}, 0);
    chk("t4_req_valid", {31'd0, icache_req_valid}, 1);
    chk("t4_req_addr", icache_req_addr, 32'h200);
    tick();
    tick();
    chk("t4_pc", inst_pc, 32'h200);
    // 5: address wrap
    do_reset();
    flush = 1;
    flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 0;
    #1;
    chk("t5_addr_top", icache_req_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("t5_addr_wrap", icache_req_addr, 32'h0);
    chk("t5_wrap_valid", {31'd0, icache_req_valid}, 1);
    chk("t5_pc", inst_pc, 32'hFFFF_FFFC);
    // 6: async reset with 5 queued and a request in flight
    do_reset();
    dispatch_ready = 0;
    for (int i = 0; i < 11; i++) tick();
    chk("t6_pre_flag", {31'd0, inst_flag}, 1);
    chk("t6_pre_wait", {31'd0, icache_req_valid}, 0);
    rst_n = 0;
    #1;
    chk("t6_req_valid", {31'd0, icache_req_valid}, 0);
    chk("t6_req_addr", icache_req_addr, 0);
    chk("t6_flag", {31'd0, inst_flag}, 0);
    chk("t6_inst", inst, 0);
    chk("t6_inst_pc", inst_pc, 0);
    do_reset();
    chk("t6_post_valid", {31'd0, icache_req_valid}, 1);
    chk("t6_post_addr", icache_req_addr, 0);
    chk("t6_post_flag", {31'd0, inst_flag}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
